// File: rtl/uart_tx_framer.sv
// UART transmit framer: valid/ready word intake, one-entry holding register,
// start / data (LSB first) / optional parity / 1-2 stop bits, one bit per tick.
module uart_tx_framer #(
    parameter int DSIZE = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic [DSIZE-1:0] din,
    input  logic [3:0]       bitWidth,
    input  logic [1:0]       parityMode,
    input  logic             stopBits,
    input  logic             load,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic             dout
);

    typedef enum logic [2:0] {IDLE, ARM, START, DATA, PARITY, STOP} state_t;

    state_t           state_q;
    logic             hold_full_q;
    logic [DSIZE-1:0] hold_data_q;
    logic [3:0]       hold_width_q;
    logic             hold_par_en_q, hold_par_bit_q, hold_stop2_q;

    logic [DSIZE-1:0] shift_q;
    logic [3:0]       width_q, cnt_q;
    logic             par_en_q, par_bit_q, stop2_q, stop_left_q;
    logic             dout_q, busy_q, done_q;

    logic [3:0]       width_d;
    logic [DSIZE-1:0] data_d;
    logic             accept, last_stop, xfer;

    always_comb begin
        width_d = (bitWidth < 4'd5 || bitWidth > 4'(DSIZE)) ? 4'(DSIZE) : bitWidth;
        for (int i = 0; i < DSIZE; i++)
            data_d[i] = din[i] && (i < int'(width_d));
    end

    assign accept    = load && !hold_full_q;
    assign last_stop = (state_q == STOP) && tick && !stop_left_q;
    // The entry moves to the shifter from IDLE or straight out of the final stop bit.
    assign xfer      = hold_full_q && ((state_q == IDLE) || last_stop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_full_q    <= 1'b0;
            hold_data_q    <= '0;
            hold_width_q   <= '0;
            hold_par_en_q  <= 1'b0;
            hold_par_bit_q <= 1'b0;
            hold_stop2_q   <= 1'b0;
        end else if (accept) begin
            hold_full_q    <= 1'b1;
            hold_data_q    <= data_d;
            hold_width_q   <= width_d;
            hold_par_en_q  <= (parityMode == 2'b01) || (parityMode == 2'b10);
            hold_par_bit_q <= (^data_d) ^ (parityMode == 2'b01);
            hold_stop2_q   <= stopBits;
        end else if (xfer) begin
            hold_full_q    <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            width_q     <= '0;
            cnt_q       <= '0;
            par_en_q    <= 1'b0;
            par_bit_q   <= 1'b0;
            stop2_q     <= 1'b0;
            stop_left_q <= 1'b0;
            dout_q      <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (hold_full_q) begin
                    state_q <= ARM;
                    busy_q  <= 1'b1;
                end
                ARM: if (tick) begin
                    state_q <= START;
                    dout_q  <= 1'b0;
                end
                START: if (tick) begin
                    state_q <= DATA;
                    cnt_q   <= '0;
                    dout_q  <= shift_q[0];
                end
                DATA: if (tick) begin
                    shift_q <= shift_q >> 1;
                    cnt_q   <= cnt_q + 4'd1;
                    if (cnt_q == width_q - 4'd1) begin
                        if (par_en_q) begin
                            state_q <= PARITY;
                            dout_q  <= par_bit_q;
                        end else begin
                            state_q     <= STOP;
                            dout_q      <= 1'b1;
                            stop_left_q <= stop2_q;
                        end
                    end else begin
                        dout_q <= shift_q[1];
                    end
                end
                PARITY: if (tick) begin
                    state_q     <= STOP;
                    dout_q      <= 1'b1;
                    stop_left_q <= stop2_q;
                end
                STOP: if (tick) begin
                    if (stop_left_q) begin
                        stop_left_q <= 1'b0;
                    end else begin
                        done_q <= 1'b1;
                        if (hold_full_q) begin
                            state_q <= START;
                            dout_q  <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            dout_q  <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
            if (xfer) begin
                shift_q   <= hold_data_q;
                width_q   <= hold_width_q;
                par_en_q  <= hold_par_en_q;
                par_bit_q <= hold_par_bit_q;
                stop2_q   <= hold_stop2_q;
            end
        end
    end

    assign ready = !hold_full_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign dout  = dout_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Randomised scoreboard bench for uart_tx_framer: accepted words become expected
// line-bit sequences; a monitor rebuilds frames from dout at each tick.
module tb_uart_tx_framer;

    logic       clk = 1'b0, reset = 1'b1, tick = 1'b0, load = 1'b0, stopBits = 1'b0;
    logic [7:0] din = '0;
    logic [3:0] bitWidth = 4'd8;
    logic [1:0] parityMode = 2'b00;
    logic       ready, busy, done, dout;

    always #5 clk = ~clk;

    uart_tx_framer #(.DSIZE(8)) dut (
        .clk(clk), .reset(reset), .tick(tick), .din(din), .bitWidth(bitWidth),
        .parityMode(parityMode), .stopBits(stopBits), .load(load),
        .ready(ready), .busy(busy), .done(done), .dout(dout)
    );

    typedef struct {
        logic [31:0] bits;
        int          len;
    } frame_t;

    frame_t     exp_q[$];
    int         start_tick[$];
    int         n_chk = 0, n_pass = 0;
    int         tcnt = 0, tperiod = 16;
    int         tick_idx = 0, frames_done = 0, done_cnt = 0;
    bit         in_frame = 0;
    frame_t     cur;
    logic [31:0] got_bits;
    int         got_len;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Line image of one frame, straight from the framing rules.
    function automatic frame_t model(input logic [7:0] d, input logic [3:0] bw,
                                     input logic [1:0] pm, input logic sb);
        frame_t f;
        int     w;
        logic   p;
        w = (bw < 5 || bw > 8) ? 8 : int'(bw);
        f.bits = '0;
        f.len  = 1;
        p      = 1'b0;
        for (int i = 0; i < w; i++) begin
            f.bits[f.len] = d[i];
            p = p ^ d[i];
            f.len++;
        end
        if (pm == 2'b01) begin f.bits[f.len] = ~p; f.len++; end
        if (pm == 2'b10) begin f.bits[f.len] = p;  f.len++; end
        for (int i = 0; i < (sb ? 2 : 1); i++) begin
            f.bits[f.len] = 1'b1;
            f.len++;
        end
        return f;
    endfunction

    task automatic next_cycle();
        @(negedge clk);
        tcnt = (tcnt + 1) % tperiod;
        tick = (tcnt == 0);
    endtask

    task automatic send(input logic [7:0] d, input logic [3:0] bw, input logic [1:0] pm,
                        input logic sb, output bit acc);
        next_cycle();
        din = d; bitWidth = bw; parityMode = pm; stopBits = sb; load = 1'b1;
        acc = ready;
        if (acc) exp_q.push_back(model(d, bw, pm, sb));
        next_cycle();
        load = 1'b0;
        din = 8'($urandom); bitWidth = 4'($urandom); parityMode = 2'($urandom);
        stopBits = 1'($urandom);
    endtask

    task automatic wait_done(input int maxc, output bit ok);
        ok = 0;
        for (int i = 0; i < maxc; i++) begin
            next_cycle();
            #1;
            if (done) begin ok = 1; break; end
        end
    endtask

    // Monitor: samples the bit being completed on each tick cycle.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (reset) begin
                exp_q.delete();
                in_frame = 0;
            end else begin
                if (done) done_cnt++;
                if (tick) begin
                    if (!in_frame) begin
                        if (dout == 1'b0) begin
                            chk("frame_expected", 32'(exp_q.size() > 0), 32'd1);
                            if (exp_q.size() > 0) begin
                                cur      = exp_q.pop_front();
                                got_bits = '0;
                                got_len  = 1;
                                in_frame = 1;
                                start_tick.push_back(tick_idx);
                            end
                        end
                    end else begin
                        got_bits[got_len] = dout;
                        got_len++;
                        if (got_len == cur.len) begin
                            chk("frame_bits", got_bits, cur.bits);
                            in_frame = 0;
                            frames_done++;
                        end
                    end
                    tick_idx++;
                end
            end
        end
    end

    initial begin
        bit acc, ok;
        int s0, d0, cyc;

        repeat (3) next_cycle();
        #1;
        chk("reset_dout", dout, 1);
        chk("reset_ready", ready, 1);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        next_cycle();
        reset = 1'b0;
        repeat (5) next_cycle();

        // 8N1 0xA5
        send(8'hA5, 4'd8, 2'b00, 1'b0, acc);
        chk("accept_8n1", acc, 1);
        repeat (2) next_cycle();
        #1;
        chk("armed_busy", busy, 1);
        chk("armed_ready", ready, 1);
        wait_done(400, ok);
        chk("done_8n1", ok, 1);
        chk("busy_falls_with_done", busy, 0);
        next_cycle();
        #1;
        chk("done_one_cycle", done, 0);

        // 8E1, 8O1, 5O2, bitWidth=3 clamp
        send(8'hA5, 4'd8, 2'b10, 1'b0, acc); wait_done(400, ok); chk("done_8e1", ok, 1);
        send(8'hA5, 4'd8, 2'b01, 1'b0, acc); wait_done(400, ok); chk("done_8o1", ok, 1);
        send(8'hFF, 4'd5, 2'b01, 1'b1, acc); wait_done(400, ok); chk("done_5o2", ok, 1);
        send(8'hFF, 4'd3, 2'b00, 1'b0, acc); wait_done(400, ok); chk("done_w3", ok, 1);
        repeat (20) next_cycle();

        // Back-to-back with a dropped third word
        s0 = start_tick.size();
        d0 = done_cnt;
        send(8'h55, 4'd8, 2'b00, 1'b0, acc);
        repeat (64) next_cycle();
        send(8'h0F, 4'd8, 2'b00, 1'b0, acc);
        chk("b2b_second_accept", acc, 1);
        #1;
        chk("b2b_ready_low", ready, 0);
        send(8'h33, 4'd8, 2'b00, 1'b0, acc);
        chk("third_dropped", acc, 0);
        wait_done(400, ok);
        chk("b2b_done1", ok, 1);
        chk("b2b_start_with_done", dout, 0);
        chk("b2b_ready_after_xfer", ready, 1);
        next_cycle();
        wait_done(400, ok);
        chk("b2b_done2", ok, 1);
        repeat (40) next_cycle();
        chk("b2b_frames", 32'(start_tick.size() - s0), 32'd2);
        if (start_tick.size() >= s0 + 2)
            chk("b2b_no_gap", 32'(start_tick[s0 + 1] - start_tick[s0]), 32'd10);
        chk("b2b_done_count", 32'(done_cnt - d0), 32'd2);

        // load coincident with tick in IDLE
        while (tcnt != tperiod - 1) next_cycle();
        next_cycle();
        din = 8'h3C; bitWidth = 4'd8; parityMode = 2'b00; stopBits = 1'b0; load = 1'b1;
        acc = ready;
        if (acc) exp_q.push_back(model(8'h3C, 4'd8, 2'b00, 1'b0));
        chk("sim_accept", acc, 1);
        next_cycle();
        load = 1'b0;
        cyc = 0;
        for (int i = 0; i < 100; i++) begin
            next_cycle();
            #1;
            cyc++;
            if (dout == 1'b0) break;
        end
        chk("sim_load_tick_latency", cyc, tperiod);
        wait_done(400, ok);
        chk("done_sim", ok, 1);
        repeat (10) next_cycle();

        // Reset mid-DATA with the holding register full
        send(8'hA5, 4'd8, 2'b10, 1'b1, acc);
        repeat (64) next_cycle();
        send(8'hC3, 4'd8, 2'b00, 1'b0, acc);
        #1;
        chk("pre_reset_full", ready, 0);
        next_cycle();
        reset = 1'b1;
        #1;
        chk("mid_reset_dout", dout, 1);
        chk("mid_reset_ready", ready, 1);
        chk("mid_reset_busy", busy, 0);
        repeat (3) next_cycle();
        reset = 1'b0;
        s0 = start_tick.size();
        d0 = done_cnt;
        repeat (600) next_cycle();
        chk("no_frame_after_reset", 32'(start_tick.size() - s0), 32'd0);
        chk("no_done_after_reset", 32'(done_cnt - d0), 32'd0);

        // Random frames, faster baud
        tperiod = 4;
        for (int n = 0; n < 30; n++) begin
            send(8'($urandom), 4'($urandom_range(3, 10)), 2'($urandom),
                 1'($urandom), acc);
            repeat ($urandom_range(0, 60)) next_cycle();
        end
        ok = 0;
        for (int i = 0; i < 5000; i++) begin
            next_cycle();
            #1;
            if (exp_q.size() == 0 && !in_frame) begin ok = 1; break; end
        end
        chk("drain", ok, 1);
        repeat (10) next_cycle();
        chk("done_count", done_cnt, frames_done);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
